popcount16_weight_enum: RTL and testbench



---
 rtl/popcount16_weight_enum_if.sv | 29 ++
 rtl/popcount16_weight_enum.sv | 105 ++++++++++
 tb/tb_popcount16_weight_enum.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/popcount16_weight_enum_if.sv
// Command / vector-stream bundle for the fixed-weight vector enumerator.
// master: harness side, slave: generator side.
interface popcount16_weight_enum_if #(
   parameter int unsigned N     = 16,
   parameter int unsigned IDX_W = 14
);
   localparam int unsigned KW = $clog2(N + 1);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [KW-1:0]    cmd_weight;
   logic             cmd_err;
   logic             vec_valid;
   logic             vec_ready;
   logic [N-1:0]     vec_data;
   logic [IDX_W-1:0] vec_index;
   logic             vec_last;
   logic             busy;

   modport master (
      output cmd_valid, cmd_weight, vec_ready,
      input  cmd_ready, cmd_err, vec_valid, vec_data, vec_index, vec_last, busy
   );

   modport slave (
      input  cmd_valid, cmd_weight, vec_ready,
      output cmd_ready, cmd_err, vec_valid, vec_data, vec_index, vec_last, busy
   );
endinterface

// File: rtl/popcount16_weight_enum.sv
// Streams every N-bit vector of Hamming weight k in increasing numeric order,
// stepping with the next-same-popcount bit trick.
module popcount16_weight_enum #(
   parameter int unsigned N     = 16,
   parameter int unsigned IDX_W = 14
) (
   input  logic                      clk,
   input  logic                      rst,
   popcount16_weight_enum_if.slave   bus
);
   localparam int unsigned KW = $clog2(N + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] EMIT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [N-1:0]     data_q, data_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic [KW-1:0]    weight_q, weight_d;
   logic             err_q, err_d;

   logic [KW-1:0]    ctz;
   logic [N-1:0]     t_fill, t_inc, low_ones, next_vec;
   logic [KW-1:0]    top_shamt;
   logic [N:0]       low_mask, first_mask;
   logic [N-1:0]     last_pat;
   logic             last_c;

   // Index of the lowest set bit of the current vector
   always_comb begin
      ctz = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (data_q[i]) ctz = KW'(i);
      end
   end

   always_comb begin
      t_fill   = data_q | (data_q - N'(1));
      t_inc    = t_fill + N'(1);
      low_ones = ((~t_fill & t_inc) - N'(1)) >> (ctz + KW'(1));
      next_vec = t_inc | low_ones;
   end

   // Final vector of a class has all k ones packed at the top
   always_comb begin
      top_shamt  = KW'(N) - weight_q;
      low_mask   = ((N+1)'(1) << top_shamt) - (N+1)'(1);
      last_pat   = ~low_mask[N-1:0];
      first_mask = ((N+1)'(1) << bus.cmd_weight) - (N+1)'(1);
      last_c     = (state_q == EMIT) && (data_q == last_pat);
   end

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      index_d  = index_q;
      weight_d = weight_q;
      err_d    = 1'b0;
      if (state_q == IDLE) begin
         if (bus.cmd_valid) begin
            if (bus.cmd_weight > KW'(N)) begin
               err_d = 1'b1;
            end else begin
               weight_d = bus.cmd_weight;
               data_d   = first_mask[N-1:0];
               index_d  = '0;
               state_d  = EMIT;
            end
         end
      end else begin
         if (bus.vec_ready) begin
            if (last_c) begin
               state_d = IDLE;
            end else begin
               data_d  = next_vec;
               index_d = index_q + IDX_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         data_q   <= '0;
         index_q  <= '0;
         weight_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         index_q  <= index_d;
         weight_q <= weight_d;
         err_q    <= err_d;
      end
   end

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.vec_valid = (state_q == EMIT);
   assign bus.busy      = (state_q == EMIT);
   assign bus.cmd_err   = err_q;
   assign bus.vec_data  = data_q;
   assign bus.vec_index = index_q;
   assign bus.vec_last  = last_c;
endmodule

// File: tb/tb_popcount16_weight_enum.sv
// Scoreboard bench for popcount16_weight_enum: expected vector streams come from
// a brute-force scan of all 16-bit values filtered by $countones.
module tb_popcount16_weight_enum;
   typedef struct packed {
      logic [15:0] data;
      logic [13:0] index;
      logic        last;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   ready_mode = 0;
   vec_t sb[$];

   popcount16_weight_enum_if #(.N(16), .IDX_W(14)) bus ();
   popcount16_weight_enum    #(.N(16), .IDX_W(14)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: every weight-k value in ascending order
   task automatic push_expected(input int k);
      int   total = 0;
      int   idx = 0;
      vec_t e;
      for (int v = 0; v < 65536; v++) if ($countones(16'(v)) == k) total++;
      for (int v = 0; v < 65536; v++) begin
         if ($countones(16'(v)) == k) begin
            e.data  = 16'(v);
            e.index = 14'(idx);
            e.last  = (idx == total - 1);
            sb.push_back(e);
            idx++;
         end
      end
   endtask

   task automatic issue(input int k);
      int w = 0;
      while (!bus.cmd_ready && w < 100) begin
         @(posedge clk); #2;
         w++;
      end
      check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
      if (k <= 16) push_expected(k);
      bus.cmd_weight = 5'(k);
      bus.cmd_valid  = 1'b1;
      @(posedge clk); #2;
      bus.cmd_valid  = 1'b0;
      if (k <= 16) begin
         check("first_valid", 32'(bus.vec_valid), 32'd1);
         check("first_index", 32'(bus.vec_index), 32'd0);
         check("busy", 32'(bus.busy), 32'd1);
         check("ready_low", 32'(bus.cmd_ready), 32'd0);
      end else begin
         check("err_pulse", 32'(bus.cmd_err), 32'd1);
         check("err_no_valid", 32'(bus.vec_valid), 32'd0);
         check("err_ready", 32'(bus.cmd_ready), 32'd1);
         @(posedge clk); #2;
         check("err_clear", 32'(bus.cmd_err), 32'd0);
         check("err_no_valid2", 32'(bus.vec_valid), 32'd0);
      end
   endtask

   task automatic drain();
      int w = 0;
      do begin
         @(posedge clk); #2;
         w++;
      end while (sb.size() != 0 && w < 20000);
      check("drain_empty", 32'(sb.size()), 32'd0);
      check("idle_ready", 32'(bus.cmd_ready), 32'd1);
      check("idle_valid", 32'(bus.vec_valid), 32'd0);
   endtask

   // Consumer ready: continuous, or random stalls of 1..5 cycles
   initial begin
      int stall = 0;
      bus.vec_ready = 1'b1;
      forever begin
         @(posedge clk); #2;
         if (ready_mode == 0) begin
            bus.vec_ready = 1'b1;
            stall = 0;
         end else if (stall > 0) begin
            bus.vec_ready = 1'b0;
            stall--;
         end else if ($urandom_range(0, 3) == 0) begin
            bus.vec_ready = 1'b0;
            stall = int'($urandom_range(1, 5)) - 1;
         end else begin
            bus.vec_ready = 1'b1;
         end
      end
   end

   // Monitor: transfers are decided at the coming posedge, sampled at negedge
   initial begin
      bit   hold = 0;
      vec_t held, cur, exp;
      forever begin
         @(negedge clk);
         cur.data  = bus.vec_data;
         cur.index = bus.vec_index;
         cur.last  = bus.vec_last;
         if (rst) begin
            hold = 0;
         end else begin
            if (hold && bus.vec_valid) check("stall_stable", 32'(cur), 32'(held));
            if (bus.vec_valid && bus.vec_ready) begin
               hold = 0;
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_vec: got %0h expected none", cur.data);
               end else begin
                  exp = sb.pop_front();
                  check("vec", 32'(cur), 32'(exp));
               end
            end else if (bus.vec_valid) begin
               hold = 1;
               held = cur;
            end else begin
               hold = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst = 1'b1;
      bus.cmd_valid  = 1'b0;
      bus.cmd_weight = '0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_vec_valid", 32'(bus.vec_valid), 32'd0);
      check("rst_vec_data",  32'(bus.vec_data),  32'd0);
      check("rst_vec_index", 32'(bus.vec_index), 32'd0);
      check("rst_vec_last",  32'(bus.vec_last),  32'd0);
      check("rst_busy",      32'(bus.busy),      32'd0);
      check("rst_cmd_err",   32'(bus.cmd_err),   32'd0);
      rst = 1'b0;
      @(posedge clk); #2;

      issue(0);  drain();
      issue(2);  drain();
      issue(8);  drain();
      issue(16); drain();
      issue(17);

      ready_mode = 1;
      issue(3);  drain();
      ready_mode = 0;
      @(posedge clk); #2;

      // Reset mid-stream while a transfer is being offered
      issue(4);
      w = 0;
      while (!(bus.vec_valid && bus.vec_index == 14'd37) && w < 1000) begin
         @(posedge clk); #2;
         w++;
      end
      check("reach_idx37", 32'(bus.vec_index), 32'd37);
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      sb.delete();
      check("midrst_valid", 32'(bus.vec_valid), 32'd0);
      check("midrst_ready", 32'(bus.cmd_ready), 32'd1);
      check("midrst_index", 32'(bus.vec_index), 32'd0);
      check("midrst_last",  32'(bus.vec_last),  32'd0);
      issue(1);
      check("k1_first_data", 32'(bus.vec_data), 32'h0001);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
